axi_lite_fifo_read_mc: RTL
==========================

# axi_lite_fifo_read_mc

Multi-channel AXI4-Lite FIFO reader: NUM_CH independent write-side stream ports each fill a private FIFO, and a processor drains them through a memory-mapped AXI4-Lite slave. It is the parametrised successor of the single-FIFO AXI-Lite read peripheral. It adds configurable data width, depth and channel count, per-channel status, sticky error flags and flush. It sits in the block design behind the AXI interconnect, with PL producers on the stream side.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width; must be ≥ log2(NUM_CH*16).
- NUM_CH, 2, number of channels, 1..4.
- FIFO_DEPTH, 16, words per channel; power of two, 4..256.
- DATA_WIDTH, 32, stream word width, 1..32; zero-extended on RDATA.
- S_AXI_ACLK  in  1  single clock for the whole block.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite slave; PROT is ignored.
- fifo_wr_data  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- fifo_wr_en  in  NUM_CH  per-channel push strobe.
- fifo_full  out  NUM_CH  per-channel full, registered.
- irq  out  1  level interrupt; present only with AXI_LITE_FIFO_READ_MC_IRQ_EN.

## Operation
- Register map: channel c base = c*0x10.
  - 0x0 DATA (RO): a read pops one word.
  - 0x4 STATUS (RO): [15:0] level, [16] empty, [17] full, [18] overflow sticky, [19] underflow sticky.
  - 0x8 CTRL (WO, reads 0): bit0 flush, bit1 clear-sticky; both self-clearing.
  - 0xC THRESH (RW, [15:0]): IRQ build only.
- Push: fifo_wr_en[c] with level<FIFO_DEPTH stores the word.
- Push while full: the word is dropped and overflow[c] is set. This holds even if a pop occurs in the same cycle.
- DATA read with level>0: returns the head word and pops it.
- DATA read when empty: returns 0 with RRESP OKAY, sets underflow[c], no pop.
- Push and pop in the same cycle: level is unchanged and both take effect.
- Flush: read/write pointers and level go to 0 on the cycle after the B handshake. A push in that same cycle is dropped and does not set overflow. Sticky flags are preserved.
- Clear-sticky: clears overflow and underflow. A new error event in the same cycle wins (the flag stays set).
- Flush and clear-sticky may be written together; both take effect.
- Unmapped addresses: reads return 0 / OKAY; writes are ignored / OKAY. Writes to RO registers are ignored.
- WSTRB applies per byte to CTRL and THRESH.
- Level arithmetic: level is log2(FIFO_DEPTH)+1 bits, zero-extended into [15:0]. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: all READY/VALID outputs 0, RDATA 0, RRESP/BRESP 0, fifo_full 0, irq 0. All levels, pointers, stickies and THRESH are 0.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle, in the cycle after both AWVALID and WVALID are seen high with no B pending.
  - BVALID rises the next cycle and holds until BREADY.
  - Only one write is outstanding at a time.
- Read channel:
  - ARREADY pulses for one cycle, in the cycle after ARVALID is seen high with no R pending.
  - The pop and the status sample happen on the AR handshake edge.
  - RVALID rises the next cycle, with RDATA held stable until RREADY.
- Read and write channels operate independently and may complete in the same cycle.
- fifo_full[c] and STATUS reflect the level after the previous edge (1-cycle latency).
- Reset asserted mid-transaction: all state clears immediately. Pending B/R are abandoned, and stored data is lost.

## Configuration
- AXI_LITE_FIFO_READ_MC_IRQ_EN defined:
  - THRESH[c] is writable.
  - irq is registered and equals the OR over c of (THRESH[c]!=0 && level[c]>=THRESH[c]), or overflow[c].
  - It asserts one cycle after the condition becomes true.
- Not defined: THRESH reads 0 and writes are ignored; the irq port and its logic are absent.

## Test plan
All scenarios use NUM_CH=2, FIFO_DEPTH=4, DATA_WIDTH=16.
- Reset release, then read 0x4 and 0x14 → both return 0x0001_0000 (empty, level 0); fifo_full=2'b00.
- Push 0xA001..0xA004 on ch0, then read 0x0 four times → 0x0000A001..0x0000A004 in order; STATUS 0x0002_0004 before the reads, 0x0001_0000 after.
- Push 5 words on ch1 → the fifth is dropped, fifo_full[1]=1, STATUS@0x14=0x0006_0004. Write 0x2 to 0x18 → STATUS=0x0002_0004.
- Read 0x0 on an empty ch0 → RDATA 0, OKAY, STATUS bit19 set, level still 0.
- With ch0 holding 3 words, write 0x1 to 0x8 while fifo_wr_en[0] pulses in the flush cycle → level 0, no overflow; 0x10/0x14 (ch1) unaffected.
- IRQ build: write 2 to 0xC, push 2 words on ch0 → irq=1 one cycle after the second push; one DATA read → irq=0 the following cycle.

Source files
------------

// File: rtl/axi_lite_fifo_read_mc.sv
// Multi-channel AXI4-Lite FIFO reader: per-channel stream FIFOs drained through memory-mapped DATA registers.
// Optional threshold/overflow interrupt is built when AXI_LITE_FIFO_READ_MC_IRQ_EN is defined.
module axi_lite_fifo_read_mc #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_CH             = 2,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned DATA_WIDTH         = 32
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      fifo_wr_data,
    input  logic [NUM_CH-1:0]                 fifo_wr_en,
    output logic [NUM_CH-1:0]                 fifo_full
`ifdef AXI_LITE_FIFO_READ_MC_IRQ_EN
    ,
    output logic                              irq
`endif
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned PAGE_W = C_S_AXI_ADDR_WIDTH - 4;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} rd_state_t;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic          awready_q, awready_nxt, bvalid_q, bvalid_nxt, wr_fire_c, b_hs_c;
    logic          arready_q, arready_nxt, rvalid_q, rvalid_nxt, rd_fire_c;
    logic [DW-1:0] rdata_q, rdata_nxt, rd_word_c;

    logic [PAGE_W-1:0] wr_page, rd_page;
    logic [1:0]        wr_off, rd_off;

    logic [DATA_WIDTH-1:0] mem [NUM_CH][FIFO_DEPTH];
    logic [LVL_W-1:0]      level [NUM_CH];
    logic [LVL_W-1:0]      level_nxt_c [NUM_CH];
    logic [PTR_W-1:0]      wptr [NUM_CH];
    logic [PTR_W-1:0]      rptr [NUM_CH];
    logic [NUM_CH-1:0]     ovf, udf, full_q, flush_q, clr_q;
    logic [NUM_CH-1:0]     flush_set_c, clr_set_c, flush_c, clr_c;
    logic [NUM_CH-1:0]     push_ok_c, pop_c, ovf_evt_c, udf_evt_c;

`ifdef AXI_LITE_FIFO_READ_MC_IRQ_EN
    logic [15:0] thresh [NUM_CH];
    logic        irq_q, irq_nxt_c;
`endif

    logic unused_sink;
    assign unused_sink = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           S_AXI_WDATA, S_AXI_WSTRB};

    assign wr_page = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
    assign wr_off  = S_AXI_AWADDR[3:2];
    assign rd_page = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
    assign rd_off  = S_AXI_ARADDR[3:2];

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign fifo_full     = full_q;

    // Channel state registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state  <= W_IDLE;
            rd_state  <= R_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wr_state  <= wr_state_nxt;
            rd_state  <= rd_state_nxt;
            awready_q <= awready_nxt;
            bvalid_q  <= bvalid_nxt;
            arready_q <= arready_nxt;
            rvalid_q  <= rvalid_nxt;
            rdata_q   <= rdata_nxt;
        end
    end

    // Write channel: accept AW+W together, one response outstanding
    always_comb begin
        wr_state_nxt = wr_state;
        awready_nxt  = 1'b0;
        bvalid_nxt   = bvalid_q;
        wr_fire_c    = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    awready_nxt  = 1'b1;
                    wr_state_nxt = W_ACK;
                end
            end
            W_ACK: begin
                wr_fire_c    = 1'b1;
                bvalid_nxt   = 1'b1;
                wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_nxt   = 1'b0;
                    wr_state_nxt = W_IDLE;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Read channel: pop and status sample on the AR handshake edge
    always_comb begin
        rd_state_nxt = rd_state;
        arready_nxt  = 1'b0;
        rvalid_nxt   = rvalid_q;
        rdata_nxt    = rdata_q;
        rd_fire_c    = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    arready_nxt  = 1'b1;
                    rd_state_nxt = R_ACK;
                end
            end
            R_ACK: begin
                rd_fire_c    = 1'b1;
                rvalid_nxt   = 1'b1;
                rdata_nxt    = rd_word_c;
                rd_state_nxt = R_RESP;
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_nxt   = 1'b0;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Register read mux; unmapped pages and offsets read as zero
    always_comb begin
        rd_word_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_page == PAGE_W'(c)) begin
                case (rd_off)
                    2'd0: if (level[c] != '0) rd_word_c = DW'(mem[c][rptr[c]]);
                    2'd1: rd_word_c = DW'({udf[c], ovf[c], level[c] == LVL_FULL,
                                           level[c] == '0, 16'(level[c])});
`ifdef AXI_LITE_FIFO_READ_MC_IRQ_EN
                    2'd3: rd_word_c = DW'(thresh[c]);
`endif
                    default: rd_word_c = '0;
                endcase
            end
        end
    end

    // Per-channel push/pop/error decode; flush suppresses pushes and overflow in its cycle
    assign b_hs_c  = bvalid_q && S_AXI_BREADY;
    assign flush_c = b_hs_c ? flush_q : '0;
    assign clr_c   = b_hs_c ? clr_q : '0;

    always_comb begin
        flush_set_c = '0;
        clr_set_c   = '0;
        push_ok_c   = '0;
        pop_c       = '0;
        ovf_evt_c   = '0;
        udf_evt_c   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            level_nxt_c[c] = level[c];
            if (wr_fire_c && wr_page == PAGE_W'(c) && wr_off == 2'd2 && S_AXI_WSTRB[0]) begin
                flush_set_c[c] = S_AXI_WDATA[0];
                clr_set_c[c]   = S_AXI_WDATA[1];
            end
            push_ok_c[c] = fifo_wr_en[c] && (level[c] != LVL_FULL) && !flush_c[c];
            ovf_evt_c[c] = fifo_wr_en[c] && (level[c] == LVL_FULL) && !flush_c[c];
            if (rd_fire_c && rd_page == PAGE_W'(c) && rd_off == 2'd0) begin
                pop_c[c]     = (level[c] != '0);
                udf_evt_c[c] = (level[c] == '0);
            end
            level_nxt_c[c] = level[c] + LVL_W'(push_ok_c[c]) - LVL_W'(pop_c[c]);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                level[c] <= '0;
                wptr[c]  <= '0;
                rptr[c]  <= '0;
            end
            ovf     <= '0;
            udf     <= '0;
            full_q  <= '0;
            flush_q <= '0;
            clr_q   <= '0;
        end else begin
            if (wr_fire_c) begin
                flush_q <= flush_set_c;
                clr_q   <= clr_set_c;
            end else if (b_hs_c) begin
                flush_q <= '0;
                clr_q   <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush_c[c]) begin
                    level[c]  <= '0;
                    wptr[c]   <= '0;
                    rptr[c]   <= '0;
                    full_q[c] <= 1'b0;
                end else begin
                    if (push_ok_c[c]) wptr[c] <= wptr[c] + PTR_W'(1);
                    if (pop_c[c])     rptr[c] <= rptr[c] + PTR_W'(1);
                    level[c]  <= level_nxt_c[c];
                    full_q[c] <= (level_nxt_c[c] == LVL_FULL);
                end
                ovf[c] <= ovf_evt_c[c] | (ovf[c] & ~clr_c[c]);
                udf[c] <= udf_evt_c[c] | (udf[c] & ~clr_c[c]);
            end
        end
    end

    // Storage is not reset; contents are only visible while level is non-zero
    always_ff @(posedge S_AXI_ACLK) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_ok_c[c]) mem[c][wptr[c]] <= fifo_wr_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef AXI_LITE_FIFO_READ_MC_IRQ_EN
    always_comb begin
        irq_nxt_c = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((thresh[c] != '0 && 16'(level[c]) >= thresh[c]) || ovf[c]) irq_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) thresh[c] <= '0;
        end else begin
            irq_q <= irq_nxt_c;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_fire_c && wr_page == PAGE_W'(c) && wr_off == 2'd3) begin
                    if (S_AXI_WSTRB[0]) thresh[c][7:0]  <= S_AXI_WDATA[7:0];
                    if (S_AXI_WSTRB[1]) thresh[c][15:8] <= S_AXI_WDATA[15:8];
                end
            end
        end
    end

    assign irq = irq_q;
`endif

endmodule
